// File: rtl/pos_cell_mem_ctrl.sv
// Read sequencer and write/read arbiter sharing one single-port cell position RAM.
// Optional build macro POS_CNT_CLAMP_EN clamps the latched particle count to PARTICLE_NUM-1.
module pos_cell_mem_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_cnt,
  output logic [DATA_WIDTH-1:0] pos_data,
  output logic                  pos_valid,
  output logic                  pos_last,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam int PW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CNT   = 3'd1,
    ST_WAIT_CNT = 3'd2,
    ST_SWEEP    = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] f_count(input logic [ADDR_WIDTH-1:0] raw);
`ifdef POS_CNT_CLAMP_EN
    if (int'(raw) > PARTICLE_NUM - 1) begin
      f_count = ADDR_WIDTH'(PARTICLE_NUM - 1);
    end else begin
      f_count = raw;
    end
`else
    f_count = raw;
`endif
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_rd_ptr;
  logic [BW-1:0]         r_burst_cnt;
  logic                  r_s1_vld, r_s1_cnt, r_s1_last;
  logic                  r_s2_vld, r_s2_cnt, r_s2_last;
  logic                  r_busy, r_done, r_pos_valid, r_pos_last;
  logic [ADDR_WIDTH-1:0] r_particle_cnt;
  logic [DATA_WIDTH-1:0] r_pos_data;

  logic                  w_cnt_arrive;
  logic [ADDR_WIDTH-1:0] w_cnt_new;
  logic [PW-1:0]         w_cnt_ext;
  logic                  w_rd_pend, w_rd_is_cnt, w_rd_last;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_wr_gnt, w_rd_gnt;

  assign w_cnt_arrive = r_s2_vld & r_s2_cnt;
  assign w_cnt_new    = f_count(mem_q[ADDR_WIDTH-1:0]);
  assign w_cnt_ext    = {1'b0, r_particle_cnt};

  // Pending read request for the current state.
  always_comb begin
    w_rd_pend   = 1'b0;
    w_rd_is_cnt = 1'b0;
    w_rd_last   = 1'b0;
    w_rd_addr   = {ADDR_WIDTH{1'b0}};
    case (r_state)
      ST_RD_CNT: begin
        w_rd_pend   = 1'b1;
        w_rd_is_cnt = 1'b1;
      end
      ST_WAIT_CNT: begin
        // Address 1 is requested in the same cycle the count word returns.
        if (w_cnt_arrive && (w_cnt_new != {ADDR_WIDTH{1'b0}})) begin
          w_rd_pend = 1'b1;
          w_rd_addr = ADDR_WIDTH'(1);
          w_rd_last = (w_cnt_new == ADDR_WIDTH'(1));
        end else begin
          w_rd_pend = 1'b0;
        end
      end
      ST_SWEEP: begin
        if (r_rd_ptr <= w_cnt_ext) begin
          w_rd_pend = 1'b1;
          w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];
          w_rd_last = (r_rd_ptr == w_cnt_ext);
        end else begin
          w_rd_pend = 1'b0;
        end
      end
      default: begin
        w_rd_pend = 1'b0;
      end
    endcase
  end

  assign w_wr_gnt = wr_req & (~w_rd_pend | (r_burst_cnt < BW'(MAX_WR_BURST)));
  assign w_rd_gnt = w_rd_pend & ~w_wr_gnt;
  assign wr_ack   = w_wr_gnt;

  // RAM port drive for the granted operation.
  always_comb begin
    mem_address = {ADDR_WIDTH{1'b0}};
    mem_data    = {DATA_WIDTH{1'b0}};
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (w_wr_gnt) begin
      mem_address = wr_addr;
      mem_data    = wr_data;
      mem_wren    = 1'b1;
    end else if (w_rd_gnt) begin
      mem_address = w_rd_addr;
      mem_rden    = 1'b1;
    end else begin
      mem_wren    = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RD_CNT;
        else       w_next = ST_IDLE;
      end
      ST_RD_CNT: begin
        if (w_rd_gnt) w_next = ST_WAIT_CNT;
        else          w_next = ST_RD_CNT;
      end
      ST_WAIT_CNT: begin
        if (!w_cnt_arrive)                                    w_next = ST_WAIT_CNT;
        else if (w_cnt_new == {ADDR_WIDTH{1'b0}})             w_next = ST_FINISH;
        else if (w_rd_gnt && (w_cnt_new == ADDR_WIDTH'(1)))   w_next = ST_DRAIN;
        else                                                  w_next = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (w_rd_gnt && w_rd_last) w_next = ST_DRAIN;
        else                       w_next = ST_SWEEP;
      end
      ST_DRAIN: begin
        if (!r_s1_vld && !r_s2_vld) w_next = ST_FINISH;
        else                        w_next = ST_DRAIN;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State, read pointer and write-burst counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rd_ptr    <= {PW{1'b0}};
      r_burst_cnt <= {BW{1'b0}};
    end else begin
      r_state <= w_next;
      if ((r_state == ST_WAIT_CNT) && w_cnt_arrive) begin
        r_rd_ptr <= w_rd_gnt ? PW'(2) : PW'(1);
      end else if ((r_state == ST_SWEEP) && w_rd_gnt) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      if (w_rd_pend && w_wr_gnt) r_burst_cnt <= r_burst_cnt + BW'(1);
      else                       r_burst_cnt <= {BW{1'b0}};
    end
  end

  // Read tracking pipeline aligned with the RAM's two-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_s1_vld, r_s1_cnt, r_s1_last} <= 3'b000;
      {r_s2_vld, r_s2_cnt, r_s2_last} <= 3'b000;
    end else begin
      {r_s1_vld, r_s1_cnt, r_s1_last} <= {w_rd_gnt, w_rd_gnt & w_rd_is_cnt, w_rd_gnt & w_rd_last};
      {r_s2_vld, r_s2_cnt, r_s2_last} <= {r_s1_vld, r_s1_cnt, r_s1_last};
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pos_valid    <= 1'b0;
      r_pos_last     <= 1'b0;
      r_pos_data     <= {DATA_WIDTH{1'b0}};
      r_particle_cnt <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (w_next == ST_FINISH);
      r_pos_valid <= r_s2_vld & ~r_s2_cnt;
      r_pos_last  <= r_s2_vld & ~r_s2_cnt & r_s2_last;
      if (r_s2_vld && !r_s2_cnt) r_pos_data <= mem_q;
      else                       r_pos_data <= r_pos_data;
      // Only the count read of the current sweep updates the latched count.
      if ((r_state == ST_WAIT_CNT) && w_cnt_arrive) r_particle_cnt <= w_cnt_new;
      else                                          r_particle_cnt <= r_particle_cnt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign pos_valid    = r_pos_valid;
  assign pos_last     = r_pos_last;
  assign pos_data     = r_pos_data;
  assign particle_cnt = r_particle_cnt;

endmodule
